// File: rtl/add32_seq.sv
`default_nettype none
// ============================================================================
// Module      : add32_seq
// Description : Chunk-serial 32-bit adder (IN1 + IN2 + CIN) with rippled carry,
//               start/ready/valid/ack handshake, COUT and signed OVERFLOW flags.
//               Optional macro ADD32_SEQ_NZ_FLAGS_EN adds ZERO/NEGATIVE outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module add32_seq #(
    parameter int CHUNK = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_in1,
    input  logic [31:0] i_in2,
    input  logic        i_cin,
    output logic        o_ready,
    output logic        o_valid,
    input  logic        i_ack,
    output logic [31:0] o_out,
    output logic        o_cout,
`ifdef ADD32_SEQ_NZ_FLAGS_EN
    output logic        o_overflow,
    output logic        o_zero,
    output logic        o_negative
`else
    output logic        o_overflow
`endif
);

    localparam int NCHUNK = 32 / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NCHUNK - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    generate
        if (CHUNK != 1 && CHUNK != 2 && CHUNK != 4 &&
            CHUNK != 8 && CHUNK != 16 && CHUNK != 32) begin : g_bad_chunk
            $fatal(1, "add32_seq: CHUNK must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_sum;
    logic [31:0]      r_out;
    logic             r_cout;
    logic             r_ovf;

    logic [5:0]       w_base;
    logic [CHUNK:0]   w_add;
    logic [31:0]      w_sum_next;
    logic             w_last;

    assign w_base = 6'(r_idx) * 6'(CHUNK);
    assign w_last = (r_idx == c_LAST_IDX);
    assign w_add  = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_b[w_base +: CHUNK]}
                  + {{CHUNK{1'b0}}, r_carry};

    // Partial sum with the current chunk merged in; on the last chunk this is the full result.
    always_comb begin
        w_sum_next                    = r_sum;
        w_sum_next[w_base +: CHUNK]   = w_add[CHUNK-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_out   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_in1;
                        r_b     <= i_in2;
                        r_carry <= i_cin;
                        r_idx   <= '0;
                        r_state <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_add[CHUNK];
                    if (w_last) begin
                        r_out   <= w_sum_next;
                        r_cout  <= w_add[CHUNK];
                        r_ovf   <= (r_a[31] == r_b[31]) && (w_sum_next[31] != r_a[31]);
                        r_state <= c_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                c_DONE: begin
                    if (i_ack) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef ADD32_SEQ_NZ_FLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (r_state == c_BUSY && w_last) begin
            r_zero <= (w_sum_next == 32'd0);
            r_neg  <= w_sum_next[31];
        end
    end

    assign o_zero     = r_zero;
    assign o_negative = r_neg;
`endif

    assign o_ready    = (r_state == c_IDLE);
    assign o_valid    = (r_state == c_DONE);
    assign o_out      = r_out;
    assign o_cout     = r_cout;
    assign o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/add32_seq.md
Name: add32_seq

Overview:
Multi-cycle 32-bit adder computing IN1 + IN2 + CIN, chunk-serial (LSB chunk first) with a rippled carry register. It is the addition counterpart of the CPU's 32-bit subtractor and produces the same flag set (OUT, COUT, OVERFLOW). A start/ready/valid/ack handshake lets the control unit issue an operation and collect the result several cycles later.

Parameters:
CHUNK, 8, bits added per cycle; legal values 1, 2, 4, 8, 16, 32; illegal value stops elaboration.
NCHUNK, 32/CHUNK, derived localparam; cycles per operation.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  synchronous reset, active-high.
START  in  1  request; accepted only when READY=1.
IN1  in  32  augend; sampled on accepted START.
IN2  in  32  addend; sampled on accepted START.
CIN  in  1  carry input, added at bit 0; sampled on accepted START.
READY  out  1  high in IDLE.
VALID  out  1  result valid; held until ACK.
ACK  in  1  consumer takes result; meaningful only while VALID=1.
OUT  out  32  sum[31:0].
COUT  out  1  carry out of bit 31.
OVERFLOW  out  1  signed overflow.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Reset values: READY=1, VALID=0, OUT=0, COUT=0, OVERFLOW=0. Internal state: IDLE, chunk index 0, carry 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: READY=1. If START=1 at an edge, latch IN1, IN2, CIN; set carry reg = CIN and index = 0; go to BUSY. READY drops on that same edge.
- BUSY: READY=0, VALID=0. Each edge adds chunk[index] of both operands plus the carry reg (CHUNK+1-bit add). The low CHUNK bits go into the sum shift register; the carry reg takes the top bit; index increments.
- Last chunk (index = NCHUNK-1) is processed on the same edge that commits OUT, COUT and OVERFLOW and enters DONE.
- Latency: VALID is high exactly NCHUNK cycles after the START-accept edge (4 for CHUNK=8, 32 for CHUNK=1).
- COUT = carry out of bit 31.
- OVERFLOW = (IN1[31] == IN2[31]) && (OUT[31] != IN1[31]), using the latched operands.
- DONE: VALID=1, READY=0. Stays in DONE while ACK=0. ACK=1 returns to IDLE on that edge (VALID=0, READY=1 next cycle).
- Output hold: OUT, COUT and OVERFLOW are updated only on entry to DONE. They keep their values through IDLE until the next result commits; they never show partial sums.
- START while BUSY or DONE: ignored; no queuing, operands not resampled.
- ACK outside DONE: ignored.
- START and ACK both high in DONE: ACK honoured, START ignored. A new START is accepted from IDLE, so the minimum issue interval is NCHUNK+2 cycles.
- Input changes after acceptance do not affect the result in flight.
- RST in any state, including mid-BUSY: on that edge go to IDLE and apply all reset values; the operation in flight is discarded.

Optional Feature:
- Macro: ADD32_SEQ_NZ_FLAGS_EN.
- Defined: adds output ports ZERO (1 bit, = (OUT == 0)) and NEGATIVE (1 bit, = OUT[31]). Both are registered, commit with OUT on entry to DONE, and reset to 0.
- Undefined: these ports do not exist; all other behaviour is identical.

Test Plan:
- CHUNK=8, IN1=0x00000001, IN2=0xFFFFFFFF, CIN=0 -> VALID 4 cycles after accept; OUT=0x00000000, COUT=1, OVERFLOW=0 (ZERO=1, NEGATIVE=0 if enabled).
- IN1=0x7FFFFFFF, IN2=0x00000001, CIN=0 -> OUT=0x80000000, COUT=0, OVERFLOW=1 (NEGATIVE=1 if enabled).
- IN1=0x000000FF, IN2=0x00000001, CIN=1 (inter-chunk carry) -> OUT=0x00000101, COUT=0, OVERFLOW=0. Repeat with CHUNK=1: same result, VALID after 32 cycles.
- IN1=0x80000000, IN2=0x80000000, CIN=0 -> OUT=0x00000000, COUT=1, OVERFLOW=1.
- Accept IN1=5, IN2=3. Pulse START with IN1=0xFFFFFFFF during BUSY; hold ACK=0 for 5 cycles after VALID -> VALID stays 1, OUT=0x00000008 throughout, second START ignored. Raise ACK together with START -> READY=1 next cycle, no new op started.
- Accept IN1=0x12345678, IN2=0x11111111; assert RST after 2 BUSY cycles -> next cycle READY=1, VALID=0, OUT=0, COUT=0, OVERFLOW=0. A following op 2+2 -> OUT=0x00000004.
